// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency, word-organised data memory answering the RV32I MEM stage.
// Define DMEM_PROTOCOL_CHECK_EN to build the sticky request-stability checker that drives err.
module data_mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_mem_address,
   input  logic [31:0] data_mem_wdata,
   input  logic [3:0]  data_mbe,
   output logic [31:0] data_mem_rdata,
   output logic        data_mem_resp,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [3:0]      count;
   logic [3:0]      count_next;
   logic            capture;
   logic            load_rdata;
   logic [AW-1:0]   rd_idx;
   logic [AW-1:0]   req_idx;
   logic            req;

   logic [AW-1:0]   cap_idx;
   logic [31:0]     cap_wdata;
   logic [3:0]      cap_mbe;
   logic            cap_rd;
   logic            cap_wr;
   logic [31:0]     rdata_q;

   logic [31:0]     mem [DEPTH];

   assign req     = data_read | data_write;
   assign req_idx = data_mem_address[AW+1:2];

   // Upper address bits alias onto the array and the byte offset is ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{data_mem_address[31:AW+2], data_mem_address[1:0]};

   // Next-state logic; the read index comes straight from the bus when a
   // zero-latency request jumps directly into RESP.
   always_comb begin
      state_next = state;
      count_next = count;
      capture    = 1'b0;
      load_rdata = 1'b0;
      rd_idx     = cap_idx;
      case (state)
         IDLE: begin
            if (req) begin
               capture = 1'b1;
               rd_idx  = req_idx;
               if (LATENCY == 0) begin
                  state_next = RESP;
                  load_rdata = 1'b1;
               end else begin
                  state_next = WAIT;
                  count_next = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (count == 4'd0) begin
               state_next = RESP;
               load_rdata = 1'b1;
            end else begin
               count_next = count - 4'd1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= 4'd0;
         cap_idx   <= '0;
         cap_wdata <= 32'd0;
         cap_mbe   <= 4'd0;
         cap_rd    <= 1'b0;
         cap_wr    <= 1'b0;
         rdata_q   <= 32'd0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (capture) begin
            cap_idx   <= req_idx;
            cap_wdata <= data_mem_wdata;
            cap_mbe   <= data_mbe;
            cap_rd    <= data_read;
            cap_wr    <= data_write;
         end
         if (load_rdata) begin
            rdata_q <= mem[rd_idx];
         end
      end
   end

   // The write lands on the edge leaving RESP, so rdata of a read+write
   // carries the pre-write word and a following read sees the new one.
   always_ff @(posedge clk) begin
      if (rst && state == RESP && cap_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (cap_mbe[b]) begin
               mem[cap_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
            end
         end
      end
   end

   assign data_mem_resp  = (state == RESP);
   assign data_mem_rdata = rdata_q;

`ifdef DMEM_PROTOCOL_CHECK_EN
   logic mismatch;
   logic err_q;

   always_comb begin
      mismatch = 1'b0;
      if (state == WAIT || state == RESP) begin
         mismatch = (data_read != cap_rd) || (data_write != cap_wr) ||
                    (req_idx != cap_idx) || (data_mbe != cap_mbe) ||
                    (cap_wr && (data_mem_wdata != cap_wdata));
      end
   end

   // Sticky until reset; the captured request is still served normally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (mismatch || (capture && data_write && data_mbe == 4'd0)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   logic unused_cap_rd;
   assign unused_cap_rd = cap_rd;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 2 and 0) checked every cycle
// against a request-level memory model, plus directed literal checks.
`timescale 1ns/1ps
module tb_data_mem_responder;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;
`ifdef DMEM_PROTOCOL_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rd    [2];
   logic        wr    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [3:0]  mbe   [2];
   logic [31:0] rdata [2];
   logic        resp  [2];
   logic        err   [2];

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
      .clk(clk), .rst(rst),
      .data_read(rd[0]), .data_write(wr[0]), .data_mem_address(addr[0]),
      .data_mem_wdata(wdata[0]), .data_mbe(mbe[0]),
      .data_mem_rdata(rdata[0]), .data_mem_resp(resp[0]), .err(err[0])
   );

   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
      .clk(clk), .rst(rst),
      .data_read(rd[1]), .data_write(wr[1]), .data_mem_address(addr[1]),
      .data_mem_wdata(wdata[1]), .data_mbe(mbe[1]),
      .data_mem_rdata(rdata[1]), .data_mem_resp(resp[1]), .err(err[1])
   );

   function automatic int latOf(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   function automatic logic [31:0] byteMask(input logic [3:0] k);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
      return m;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Request-level model: one outstanding request per instance, response due
   // LATENCY+1 cycles after capture, bytes committed when the response ends.
   int          cyc = 0;
   bit          pend     [2];
   int          resp_cyc [2];
   int          p_idx    [2];
   logic [31:0] p_wdata  [2];
   logic [31:0] p_exp    [2];
   logic [3:0]  p_mbe    [2];
   logic [3:0]  p_known  [2];
   logic        p_rd     [2];
   logic        p_wr     [2];
   bit          exp_err  [2];
   logic [31:0] mmem   [2][DEPTH];
   logic [3:0]  mknown [2][DEPTH];

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            for (int i = 0; i < 2; i++) begin
               pend[i]    = 1'b0;
               exp_err[i] = 1'b0;
            end
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (pend[i]) begin
                  if (CHK && (rd[i] !== p_rd[i] || wr[i] !== p_wr[i] ||
                              int'(addr[i][AW+1:2]) != p_idx[i] || mbe[i] !== p_mbe[i] ||
                              (p_wr[i] && wdata[i] !== p_wdata[i])))
                     exp_err[i] = 1'b1;
                  if (cyc == resp_cyc[i]) begin
                     if (p_wr[i]) begin
                        for (int b = 0; b < 4; b++) begin
                           if (p_mbe[i][b]) begin
                              mmem[i][p_idx[i]][8*b +: 8] = p_wdata[i][8*b +: 8];
                              mknown[i][p_idx[i]][b]      = 1'b1;
                           end
                        end
                     end
                     pend[i] = 1'b0;
                  end
               end else if (rd[i] || wr[i]) begin
                  pend[i]     = 1'b1;
                  resp_cyc[i] = cyc + 1 + latOf(i);
                  p_idx[i]    = int'(addr[i][AW+1:2]);
                  p_wdata[i]  = wdata[i];
                  p_mbe[i]    = mbe[i];
                  p_rd[i]     = rd[i];
                  p_wr[i]     = wr[i];
                  p_exp[i]    = mmem[i][p_idx[i]];
                  p_known[i]  = mknown[i][p_idx[i]];
                  if (CHK && wr[i] && mbe[i] == 4'd0) exp_err[i] = 1'b1;
               end
            end
            cyc++;
         end
      end
   end

   // Every-cycle comparison of resp, err and (when meaningful) rdata.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         automatic logic exp_resp;
         automatic logic [31:0] m;
         exp_resp = rst && pend[i] && (cyc == resp_cyc[i]);
         m        = byteMask(p_known[i]);
         checkOutput($sformatf("resp[%0d]", i), 32'(resp[i]), 32'(exp_resp));
         checkOutput($sformatf("err[%0d]", i), 32'(err[i]), 32'(exp_err[i]));
         if (!rst)
            checkOutput($sformatf("rdata_in_reset[%0d]", i), rdata[i], 32'd0);
         else if (exp_resp && p_known[i] != 4'd0)
            checkOutput($sformatf("rdata[%0d]", i), rdata[i] & m, p_exp[i] & m);
      end
   end

   task automatic waitResp(input int i, output int lat, output logic [31:0] data);
      int n = 0;
      lat  = -1;
      data = 32'd0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (resp[i]) begin
            lat  = n - 1;
            data = rdata[i];
            break;
         end
      end
      if (lat < 0) checkOutput($sformatf("resp_timeout[%0d]", i), 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int i, input logic r, input logic w,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] m, output int lat, output logic [31:0] data);
      rd[i]    = r;
      wr[i]    = w;
      addr[i]  = a;
      wdata[i] = d;
      mbe[i]   = m;
      waitResp(i, lat, data);
   endtask

   task automatic idleCycles(input int i, input int n);
      rd[i] = 1'b0;
      wr[i] = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic randomPhase(input int i, input int count);
      logic [31:0] a, d;
      logic [3:0]  m;
      int          op, lat;
      logic [31:0] data;
      for (int k = 0; k < count; k++) begin
         a  = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
         d  = $urandom();
         m  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom());
         op = $urandom_range(0, 3);
         applyStimulus(i, op != 2, op >= 2, a, d, m, lat, data);
         if ($urandom_range(0, 1) == 1) idleCycles(i, $urandom_range(1, 2));
      end
      idleCycles(i, 2);
   endtask

   initial begin
      int          lat;
      logic [31:0] data;
      for (int i = 0; i < 2; i++) begin
         rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0; mbe[i] = 4'd0;
         for (int j = 0; j < DEPTH; j++) begin
            mmem[i][j]   = 32'd0;
            mknown[i][j] = 4'd0;
         end
      end

      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      idleCycles(0, 2);
      checkOutput("reset_resp", 32'(resp[0]), 32'd0);
      checkOutput("reset_rdata", rdata[0], 32'd0);
      checkOutput("reset_err", 32'(err[0]), 32'd0);

      // LATENCY = 2: full-word write then read back.
      applyStimulus(0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, lat, data);
      checkOutput("wr_latency", 32'(lat), 32'd3);
      applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'd0, 4'hF, lat, data);
      checkOutput("rd_latency", 32'(lat), 32'd3);
      checkOutput("rd_deadbeef", data, 32'hDEADBEEF);

      // Single-lane write merges into the existing word.
      applyStimulus(0, 1'b0, 1'b1, 32'h104, 32'h11223344, 4'hF, lat, data);
      applyStimulus(0, 1'b0, 1'b1, 32'h104, 32'h0000AA00, 4'b0010, lat, data);
      applyStimulus(0, 1'b1, 1'b0, 32'h104, 32'd0, 4'hF, lat, data);
      checkOutput("byte_merge", data, 32'h1122AA44);

      // Read+write together returns the old word, commits the new one.
      applyStimulus(0, 1'b0, 1'b1, 32'h200, 32'h1, 4'hF, lat, data);
      applyStimulus(0, 1'b1, 1'b1, 32'h200, 32'h2, 4'hF, lat, data);
      checkOutput("rw_old_word", data, 32'h1);
      applyStimulus(0, 1'b1, 1'b0, 32'h200, 32'd0, 4'hF, lat, data);
      checkOutput("rw_new_word", data, 32'h2);

      // Reset during WAIT of a write aborts it.
      applyStimulus(0, 1'b0, 1'b1, 32'h300, 32'h55, 4'hF, lat, data);
      applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'd0, 4'hF, lat, data);
      rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h300; wdata[0] = 32'h99; mbe[0] = 4'hF;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checkOutput("abort_resp", 32'(resp[0]), 32'd0);
      checkOutput("abort_rdata", rdata[0], 32'd0);
      wr[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      idleCycles(0, 1);
      applyStimulus(0, 1'b1, 1'b0, 32'h300, 32'd0, 4'hF, lat, data);
      checkOutput("abort_no_commit", data, 32'h55);

`ifdef DMEM_PROTOCOL_CHECK_EN
      // Address moved during WAIT: err rises and sticks, original word returned.
      applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hCAFE0010, 4'hF, lat, data);
      rd[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h10; mbe[0] = 4'hF;
      @(posedge clk);
      #1;
      checkOutput("err_before", 32'(err[0]), 32'd0);
      addr[0] = 32'h14;
      waitResp(0, lat, data);
      checkOutput("err_set", 32'(err[0]), 32'd1);
      checkOutput("err_rdata", data, 32'hCAFE0010);
      idleCycles(0, 2);
      checkOutput("err_sticky", 32'(err[0]), 32'd1);
`endif

      // Zero byte enables leave storage alone but still respond.
      applyStimulus(0, 1'b0, 1'b1, 32'h104, 32'hFFFFFFFF, 4'h0, lat, data);
      checkOutput("mbe0_latency", 32'(lat), 32'd3);
      applyStimulus(0, 1'b1, 1'b0, 32'h104, 32'd0, 4'hF, lat, data);
      checkOutput("mbe0_unchanged", data, 32'h1122AA44);

      // Upper address bits alias onto the same word.
      applyStimulus(0, 1'b0, 1'b1, 32'h100 + 32'h1000, 32'h0BADF00D, 4'hF, lat, data);
      applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'd0, 4'hF, lat, data);
      checkOutput("alias", data, 32'h0BADF00D);
      idleCycles(0, 2);

      randomPhase(0, 150);

      // LATENCY = 0: back-to-back reads held high, one response every 2nd cycle.
      for (int k = 0; k < 4; k++)
         applyStimulus(1, 1'b0, 1'b1, 32'(k * 4), 32'hA0A0_0000 + 32'(k), 4'hF, lat, data);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, 1'b1, 1'b0, 32'(k * 4), 32'd0, 4'hF, lat, data);
         checkOutput($sformatf("b2b_latency_%0d", k), 32'(lat), 32'd1);
         checkOutput($sformatf("b2b_rdata_%0d", k), data, 32'hA0A0_0000 + 32'(k));
      end
      idleCycles(1, 2);

      randomPhase(1, 150);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish, mismatched=%0d", mismatched);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Memory-side responder for the CPU's data port.
- Accepts read/write requests (read, write, address, wdata, byte enables) from the pipelined RV32I datapath's MEM stage.
- Returns a single-cycle `data_mem_resp` pulse after a fixed, parameterised wait. Read data is valid in that same cycle.
- Backed by an internal word-organised storage array.
- Serves as the bench and FPGA stand-in for the data cache/memory on the datapath's stall-until-resp interface.

## Interface
- `DEPTH`, default 1024: storage size in 32-bit words; power of two, ≥ 4.
- `LATENCY`, default 2: wait cycles between request capture and resp; 0–15.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; asynchronous, active-low.
- `data_read`  input  1  read request; held high until resp.
- `data_write`  input  1  write request; held high until resp.
- `data_mem_address`  input  32  byte address; bits [1:0] ignored.
- `data_mem_wdata`  input  32  write data, already lane-shifted.
- `data_mbe`  input  4  byte enables; bit i enables wdata[8i+7:8i].
- `data_mem_rdata`  output  32  read word; valid only while resp=1.
- `data_mem_resp`  output  1  completion pulse, exactly one cycle per request.
- `err`  output  1  sticky protocol-error flag; see Configuration.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, with `data_read | data_write` high at a rising edge:
  - Capture address word index `addr[log2(DEPTH)+1:2]`, wdata, mbe, rd and wr flags.
  - Go to WAIT with counter = LATENCY−1, or go straight to RESP if LATENCY = 0.
- WAIT: decrement the counter each cycle. At counter = 0, go to RESP.
- RESP:
  - resp = 1; rdata = storage word at the captured index.
  - On the edge leaving RESP, commit the write: byte i of the word is updated iff captured mbe[i] = 1.
  - Always return to IDLE. A request still high in the following IDLE cycle is a new request; the datapath has advanced.
- Read data is sampled on the edge entering RESP and held in an rdata register until the next RESP.
- Address bits above the index alias; there is no range fault.
- Read and write both high: the write is committed, and rdata returns the pre-write word.
- Write with mbe = 0: storage unchanged; resp still issued.
- Inputs are ignored in WAIT and RESP; the request is served using the captured values.

## Timing
- Request first high in IDLE at cycle t: resp high in cycle t+1+LATENCY, low in every other cycle.
- Back-to-back requests: next resp no earlier than t+1+LATENCY+1+1+LATENCY. The throughput is one request per LATENCY+2 cycles.
- A read issued immediately after a write to the same word returns the new data, because the commit happens at the end of RESP.
- Reset values, all outputs: resp = 0, rdata = 0, err = 0. FSM to IDLE, counter = 0.
- Storage contents are not reset.
- Reset asserted mid-request: abort immediately. No write commit, no resp. Resume in IDLE once reset is released.

## Configuration
- `DMEM_PROTOCOL_CHECK_EN` defined:
  - In WAIT or RESP, `err` is set if any of these differ from the captured values: read, write, address index, wdata (on writes), mbe.
  - `err` is also set on capture of a write with mbe = 0.
  - `err` is sticky and cleared only by reset.
  - Service is unaffected: the captured request still completes.
- `DMEM_PROTOCOL_CHECK_EN` undefined: `err` is tied to 0 and no compare logic is built.

## Test plan
- LATENCY = 2, write 0xDEADBEEF to 0x100 with mbe = 4'b1111, then read 0x100 → resp 3 cycles after each request; read rdata = 0xDEADBEEF.
- Word at 0x104 = 0x11223344; write wdata = 0x0000AA00 with mbe = 4'b0010, then read → 0x1122AA44.
- LATENCY = 0, reads held continuously high across 4 requests to 0x0, 0x4, 0x8, 0xC → resp every 2nd cycle; each rdata matches its preloaded word.
- Read and write high together at 0x200 (old 0x1, wdata 0x2) → resp rdata = 0x1; a subsequent read returns 0x2.
- Reset pulsed low during WAIT of a write to 0x300 → no resp; 0x300 unchanged; resp = 0, rdata = 0 immediately.
- With `DMEM_PROTOCOL_CHECK_EN`, address changed from 0x10 to 0x14 during WAIT → err = 1 from the next cycle and stays 1; resp still returns the word at 0x10.
